// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer and its register file.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        AND = 4'd0,
        OR  = 4'd1,
        ADD = 4'd2,
        INC = 4'd3,
        DEC = 4'd4,
        NOT = 4'd5,
        SUB = 4'd6,
        XOR = 4'd7,
        SHL = 4'd8,
        SHR = 4'd9
    } alu_op_t;

    // Op codes above this are still sent to the ALU but flagged as errors.
    localparam logic [3:0] ALU_OP_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        RESP
    } state_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// Operand register file: synchronous reset, two async reads, two writes.
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int BITS  = 4,
    parameter int NREGS = 4,
    parameter int RA_W  = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_en,
    input  logic [RA_W-1:0] wb_addr,
    input  logic [BITS-1:0] wb_data,
    input  logic            ld_en,
    input  logic [RA_W-1:0] ld_addr,
    input  logic [BITS-1:0] ld_data,
    input  logic [RA_W-1:0] rd_addr_a,
    output logic [BITS-1:0] rd_data_a,
    input  logic [RA_W-1:0] rd_addr_b,
    output logic [BITS-1:0] rd_data_b
);

    logic [BITS-1:0] regs [NREGS];

    // The writeback assignment comes last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (ld_en) begin
                regs[ld_addr] <= ld_data;
            end
            if (wb_en) begin
                regs[wb_addr] <= wb_data;
            end
        end
    end

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one command at a time through an external combinational ALU,
// with operands from a small register file and a valid/ready response.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int BITS  = 4,
    parameter int NREGS = 4,
    parameter int RA_W  = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [3:0]      cmd_op,
    input  logic [RA_W-1:0] cmd_src_a,
    input  logic [RA_W-1:0] cmd_src_b,
    input  logic [RA_W-1:0] cmd_dst,
    input  logic            cmd_wb,
    input  logic            cmd_flag_in,
    input  logic            cmd_flag_sel,
    input  logic            ld_en,
    input  logic [RA_W-1:0] ld_addr,
    input  logic [BITS-1:0] ld_data,
    output logic [BITS-1:0] alu_a,
    output logic [BITS-1:0] alu_b,
    output logic [3:0]      alu_control,
    output logic            alu_flag_in,
    input  logic [BITS-1:0] alu_result,
    input  logic            alu_zero,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [BITS-1:0] rsp_result,
    output logic            rsp_zero,
    output logic            rsp_err,
    output logic            busy
);

    state_t state, next_state;

    logic [3:0]      op_q;
    logic [RA_W-1:0] src_a_q, src_b_q, dst_q;
    logic            wb_q, flag_in_q, flag_sel_q;
    logic            stored_zero;

    logic            op_err;
    logic            wb_en;
    logic [BITS-1:0] rd_data_a, rd_data_b;

    assign op_err = (op_q > ALU_OP_MAX);
    assign wb_en  = (state == EXEC) && wb_q && !op_err;

    alu_seq_regfile #(
        .BITS  (BITS),
        .NREGS (NREGS),
        .RA_W  (RA_W)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_en     (wb_en),
        .wb_addr   (dst_q),
        .wb_data   (alu_result),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .rd_addr_a (src_a_q),
        .rd_data_a (rd_data_a),
        .rd_addr_b (src_b_q),
        .rd_data_b (rd_data_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    next_state = FETCH;
                end
            end
            FETCH: next_state = EXEC;
            EXEC:  next_state = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // ALU drive registers only change in FETCH; response fields only in EXEC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q        <= '0;
            src_a_q     <= '0;
            src_b_q     <= '0;
            dst_q       <= '0;
            wb_q        <= 1'b0;
            flag_in_q   <= 1'b0;
            flag_sel_q  <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            alu_flag_in <= 1'b0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_err     <= 1'b0;
            stored_zero <= 1'b0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                op_q       <= cmd_op;
                src_a_q    <= cmd_src_a;
                src_b_q    <= cmd_src_b;
                dst_q      <= cmd_dst;
                wb_q       <= cmd_wb;
                flag_in_q  <= cmd_flag_in;
                flag_sel_q <= cmd_flag_sel;
            end
            if (state == FETCH) begin
                alu_a       <= rd_data_a;
                alu_b       <= rd_data_b;
                alu_control <= op_q;
                alu_flag_in <= flag_sel_q ? stored_zero : flag_in_q;
            end
            if (state == EXEC) begin
                rsp_result  <= alu_result;
                rsp_zero    <= alu_zero;
                rsp_err     <= op_err;
                stored_zero <= alu_zero;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural ALU model.
module tb_alu_sequencer;

    localparam int BITS  = 4;
    localparam int NREGS = 4;
    localparam int RA_W  = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [3:0]      cmd_op;
    logic [RA_W-1:0] cmd_src_a, cmd_src_b, cmd_dst;
    logic            cmd_wb, cmd_flag_in, cmd_flag_sel;
    logic            ld_en;
    logic [RA_W-1:0] ld_addr;
    logic [BITS-1:0] ld_data;
    logic [BITS-1:0] alu_a, alu_b, alu_result;
    logic [3:0]      alu_control;
    logic            alu_flag_in, alu_zero;
    logic            rsp_valid, rsp_ready, rsp_zero, rsp_err, busy;
    logic [BITS-1:0] rsp_result;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.BITS(BITS), .NREGS(NREGS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_src_a    (cmd_src_a),
        .cmd_src_b    (cmd_src_b),
        .cmd_dst      (cmd_dst),
        .cmd_wb       (cmd_wb),
        .cmd_flag_in  (cmd_flag_in),
        .cmd_flag_sel (cmd_flag_sel),
        .ld_en        (ld_en),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_control  (alu_control),
        .alu_flag_in  (alu_flag_in),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    // Stand-in ALU: ADD folds in the flag as carry-in, unknown ops give 0.
    always_comb begin
        case (alu_control)
            4'd0:    alu_result = alu_a & alu_b;
            4'd1:    alu_result = alu_a | alu_b;
            4'd2:    alu_result = alu_a + alu_b + {3'b000, alu_flag_in};
            4'd3:    alu_result = alu_a + 4'd1;
            4'd4:    alu_result = alu_a - 4'd1;
            4'd5:    alu_result = ~alu_a;
            4'd6:    alu_result = alu_a - alu_b;
            4'd7:    alu_result = alu_a ^ alu_b;
            4'd8:    alu_result = alu_a << 1;
            4'd9:    alu_result = alu_a >> 1;
            default: alu_result = 4'd0;
        endcase
        alu_zero = (alu_result == 4'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic loadReg(input logic [RA_W-1:0] addr, input logic [BITS-1:0] data);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        tick();
        ld_en   = 1'b0;
    endtask

    // Returns one cycle after the accept edge, i.e. with the DUT in FETCH.
    task automatic applyStimulus(input logic [3:0] op, input logic [RA_W-1:0] src_a,
                                 input logic [RA_W-1:0] src_b, input logic [RA_W-1:0] dst,
                                 input logic wb, input logic flag_in, input logic flag_sel);
        cmd_op       = op;
        cmd_src_a    = src_a;
        cmd_src_b    = src_b;
        cmd_dst      = dst;
        cmd_wb       = wb;
        cmd_flag_in  = flag_in;
        cmd_flag_sel = flag_sel;
        cmd_valid    = 1'b1;
        for (int i = 0; i < 16 && cmd_ready !== 1'b1; i++) tick();
        checkOutput("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic waitResponse();
        for (int i = 0; i < 16 && rsp_valid !== 1'b1; i++) tick();
        checkOutput("rsp_valid_wait", {31'd0, rsp_valid}, 32'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_op       = '0;
        cmd_src_a    = '0;
        cmd_src_b    = '0;
        cmd_dst      = '0;
        cmd_wb       = 1'b0;
        cmd_flag_in  = 1'b0;
        cmd_flag_sel = 1'b0;
        ld_en        = 1'b0;
        ld_addr      = '0;
        ld_data      = '0;
        rsp_ready    = 1'b1;

        tick();
        tick();
        checkOutput("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset_rsp_result", {28'd0, rsp_result}, 32'd0);
        rst_n = 1'b1;

        loadReg(2'd0, 4'd5);
        loadReg(2'd1, 4'd3);

        // ADD r0+r1 -> r2, cycle-exact latency
        applyStimulus(4'd2, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0);
        checkOutput("c1_busy", {31'd0, busy}, 32'd1);
        checkOutput("c1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        checkOutput("c1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        checkOutput("c2_alu_a", {28'd0, alu_a}, 32'd5);
        checkOutput("c2_alu_b", {28'd0, alu_b}, 32'd3);
        checkOutput("c2_alu_control", {28'd0, alu_control}, 32'd2);
        checkOutput("c2_alu_flag_in", {31'd0, alu_flag_in}, 32'd0);
        checkOutput("c2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        checkOutput("c3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("add_result", {28'd0, rsp_result}, 32'd8);
        checkOutput("add_zero", {31'd0, rsp_zero}, 32'd0);
        checkOutput("add_err", {31'd0, rsp_err}, 32'd0);
        checkOutput("add_r2", {28'd0, dut.u_regfile.regs[2]}, 32'd8);
        tick();
        checkOutput("c4_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // SUB r0-r0 sets the stored zero flag
        applyStimulus(4'd6, 2'd0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
        waitResponse();
        checkOutput("sub_result", {28'd0, rsp_result}, 32'd0);
        checkOutput("sub_zero", {31'd0, rsp_zero}, 32'd1);
        tick();

        // ADD with flag_sel picks up the stored zero as carry-in: 5+3+1
        applyStimulus(4'd2, 2'd0, 2'd1, 2'd3, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("flagsel_alu_flag_in", {31'd0, alu_flag_in}, 32'd1);
        waitResponse();
        checkOutput("flagsel_result", {28'd0, rsp_result}, 32'd9);
        tick();

        // Backpressure: response held five cycles
        rsp_ready = 1'b0;
        applyStimulus(4'd2, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
        waitResponse();
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            checkOutput("bp_rsp_result", {28'd0, rsp_result}, 32'd8);
            checkOutput("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            checkOutput("bp_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        checkOutput("bp_release_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("bp_release_busy", {31'd0, busy}, 32'd0);
        checkOutput("bp_release_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // Error op 12: flagged, no writeback, stored zero still updated
        loadReg(2'd3, 4'd7);
        applyStimulus(4'd12, 2'd0, 2'd1, 2'd3, 1'b1, 1'b0, 1'b0);
        waitResponse();
        checkOutput("err_flag", {31'd0, rsp_err}, 32'd1);
        checkOutput("err_result", {28'd0, rsp_result}, 32'd0);
        checkOutput("err_zero", {31'd0, rsp_zero}, 32'd1);
        checkOutput("err_r3_kept", {28'd0, dut.u_regfile.regs[3]}, 32'd7);
        tick();
        applyStimulus(4'd2, 2'd0, 2'd1, 2'd3, 1'b0, 1'b0, 1'b1);
        waitResponse();
        checkOutput("err_stored_zero_result", {28'd0, rsp_result}, 32'd9);
        tick();

        // Load and writeback to r2 on the same edge: writeback wins
        loadReg(2'd2, 4'd1);
        applyStimulus(4'd2, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0);
        tick();
        ld_en   = 1'b1;
        ld_addr = 2'd2;
        ld_data = 4'hF;
        tick();
        ld_en = 1'b0;
        checkOutput("collide_r2", {28'd0, dut.u_regfile.regs[2]}, 32'd8);
        tick();

        // Load to r1 and writeback to r2 on the same edge: both land
        loadReg(2'd2, 4'd1);
        applyStimulus(4'd2, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0);
        tick();
        ld_en   = 1'b1;
        ld_addr = 2'd1;
        ld_data = 4'd6;
        tick();
        ld_en = 1'b0;
        checkOutput("both_r2", {28'd0, dut.u_regfile.regs[2]}, 32'd8);
        checkOutput("both_r1", {28'd0, dut.u_regfile.regs[1]}, 32'd6);
        checkOutput("both_result", {28'd0, rsp_result}, 32'd8);
        tick();

        // Load to r1 during FETCH: operand sees the old value 6
        applyStimulus(4'd2, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
        ld_en   = 1'b1;
        ld_addr = 2'd1;
        ld_data = 4'd2;
        tick();
        ld_en = 1'b0;
        checkOutput("fetch_load_alu_b", {28'd0, alu_b}, 32'd6);
        checkOutput("fetch_load_r1", {28'd0, dut.u_regfile.regs[1]}, 32'd2);
        waitResponse();
        checkOutput("fetch_load_result", {28'd0, rsp_result}, 32'hB);
        tick();

        // Reset during EXEC drops the command
        applyStimulus(4'd2, 2'd0, 2'd1, 2'd3, 1'b1, 1'b0, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst_alu_a", {28'd0, alu_a}, 32'd0);
        checkOutput("rst_alu_b", {28'd0, alu_b}, 32'd0);
        checkOutput("rst_rsp_result", {28'd0, rsp_result}, 32'd0);
        for (int i = 0; i < NREGS; i++) begin
            checkOutput($sformatf("rst_reg%0d", i), {28'd0, dut.u_regfile.regs[i]}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Command-driven controller that sequences the team's parameterised ALU through a small operand register file.
- Accepts one ALU command at a time over a valid/ready handshake.
- Fetches operands from the register file and drives the ALU's combinational ports from registers.
- Captures result and zero flag, optionally writes the result back, and returns it over a valid/ready response channel.
- Sits between the instruction/test front-end and the ALU instance; the ALU stays external and is connected through the alu_* ports.

Parameters:
BITS, 4, datapath width; must match the ALU instance's width.
NREGS, 4, number of operand registers (power of two, at least 2).
RA_W, $clog2(NREGS), register address width (derived; do not override).

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  synchronous reset, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_op  in  4  ALU operation code, forwarded to alu_control
cmd_src_a  in  RA_W  register index for ALU A operand
cmd_src_b  in  RA_W  register index for ALU B operand
cmd_dst  in  RA_W  writeback register index
cmd_wb  in  1  1 = write result to cmd_dst
cmd_flag_in  in  1  explicit ALU flag input
cmd_flag_sel  in  1  0 = use cmd_flag_in; 1 = use stored zero flag from the last completed command
ld_en  in  1  direct register-file write, accepted in any state
ld_addr  in  RA_W  load address
ld_data  in  BITS  load data
alu_a  out  BITS  registered A operand to ALU
alu_b  out  BITS  registered B operand to ALU
alu_control  out  4  registered op code to ALU
alu_flag_in  out  1  registered flag input to ALU
alu_result  in  BITS  ALU combinational result
alu_zero  in  1  ALU zero flag (bit 0 of the ALU flags output)
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer ready
rsp_result  out  BITS  captured result
rsp_zero  out  1  captured zero flag
rsp_err  out  1  op code outside 0..9
busy  out  1  state is not IDLE

Behaviour:
- Reset (rst_n low at a clock edge) forces:
  - state to IDLE;
  - all registers, alu_*, rsp_* and the stored zero flag to 0.
- Reset overrides everything, including mid-command. An in-flight command is dropped with no writeback and no response.
- FSM states: IDLE, FETCH, EXEC, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch all cmd_* fields and go to FETCH.
- FETCH:
  - alu_a <= reg[src_a], alu_b <= reg[src_b], alu_control <= op.
  - alu_flag_in <= (flag_sel ? stored_zero : flag_in).
  - Go to EXEC.
- EXEC:
  - Sample alu_result and alu_zero into rsp_result and rsp_zero.
  - rsp_err <= (op > 9).
  - If cmd_wb=1 and op ≤ 9, write reg[dst] <= alu_result.
  - stored_zero <= alu_zero.
  - Go to RESP.
- RESP: rsp_valid=1, with rsp_result, rsp_zero and rsp_err held stable. On rsp_ready, go to IDLE.
- Latency and throughput:
  - Accept edge = cycle 0; rsp_valid is high from cycle 3.
  - Minimum 4 cycles per command, with back-to-back acceptance on the cycle after the response handshake.
- Backpressure: with rsp_ready low, the block stays in RESP indefinitely and cmd_ready stays 0.
- Error opcodes (10..15):
  - Still issued to the ALU; its default behaviour applies.
  - rsp_err=1, writeback is suppressed, stored_zero is still updated.
- Load port timing: a load writes on the edge where ld_en is high.
  - A load in FETCH to a source being read: the read returns the pre-load value.
  - Load and EXEC writeback to the same address on the same edge: the writeback wins.
  - Different addresses: both writes occur.
- alu_* outputs hold their last values outside FETCH.
- The ALU is assumed purely combinational with settle time under one cycle. The A/B operand paths must be registered.

Decomposition:
- Shared package alu_seq_pkg holds:
  - alu_op_t enum: AND=0, OR=1, ADD=2, INC=3, DEC=4, NOT=5, SUB=6, XOR=7, SHL=8, SHR=9;
  - constant ALU_OP_MAX=9;
  - state_t enum {IDLE, FETCH, EXEC, RESP}.
- One sub-module, alu_seq_regfile: NREGS×BITS array with synchronous reset, two async read ports, and two write ports with fixed priority (writeback over load).

Test Plan:
- Load r0=5, r1=3; cmd ADD src_a=0 src_b=1 dst=2 wb=1 flag_in=0 -> rsp_valid at cycle 3, rsp_result=8, rsp_zero=0, r2=8.
- cmd SUB r0-r0 (5-5) -> rsp_result=0, rsp_zero=1. Then ADD r0+r1 with flag_sel=1 -> alu_flag_in=1, rsp_result=9.
- Backpressure: hold rsp_ready=0 for 5 cycles during RESP -> rsp_valid stays 1, rsp_result stable, cmd_ready=0, busy=1. Release -> IDLE next cycle.
- cmd op=4'b1100 dst=3 wb=1 with r3=7 -> rsp_err=1, r3 remains 7.
- ld_en addr=2 data=0xF on the same edge as an EXEC writeback of 8 to r2 -> r2=8. A load to r1 during FETCH reading r1 -> alu_b carries the old r1.
- rst_n=0 for one edge during EXEC -> next cycle state IDLE, rsp_valid=0, alu_a=alu_b=0, all registers 0, cmd_ready=1.
